pipe_ctrl_regs: RTL and testbench

Consumer side of the single-cycle control decoder: takes the decoded control bundle produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage CPU. It also detects load-use hazards (stall plus bubble), applies branch and jump flushes, and sanitizes don't-care or NOP control bits so no X reaches architectural state. It sits between the ID-stage decoder and the EX/MEM/WB datapath muxes, register file, and data memory. It also drives the PC and IF/ID write enables.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/hazard_detect.sv | 21 ++
 rtl/pipe_ctrl_regs.sv | 166 ++++++++++++++++
 tb/tb_pipe_ctrl_regs.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Control-bundle types and constants shared by the ID decoder and the
// pipeline control registers.
package cpu_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_bundle;

    localparam ctrl_bundle CTRL_BUBBLE = '0;

    // Controls that still matter once an instruction has left ID; jump only
    // steers fetch, so it is folded away on entry to EX.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '0;

    // A jump that also decodes as a branch must not resolve as a branch later.
    function automatic idex_ctrl_t to_idex(ctrl_bundle c);
        idex_ctrl_t r;
        r.reg_dst    = c.reg_dst;
        r.alu_src    = c.alu_src;
        r.mem_to_reg = c.mem_to_reg;
        r.reg_write  = c.reg_write;
        r.mem_read   = c.mem_read;
        r.mem_write  = c.mem_write;
        r.branch     = c.branch & ~c.jump;
        r.alu_op     = c.alu_op;
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose target register is read by
// the instruction in ID forces a one-cycle stall, unless a flush is pending.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             mem_branch_taken,
    output logic             stall
);

    logic rt_live;
    logic rt_match;

    assign rt_live  = (idex_rt != '0);
    assign rt_match = (idex_rt == id_rs) | (idex_rt == id_rt);
    assign stall    = idex_mem_read & rt_live & rt_match & ~mem_branch_taken;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Carries decoded controls through ID/EX, EX/MEM and MEM/WB, inserting
// bubbles for load-use stalls, taken branches and NOPs.
module pipe_ctrl_regs
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_nop,
    input  logic             id_reg_dst,
    input  logic             id_alu_src,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [1:0]       id_alu_op,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             mem_branch_taken,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic [1:0]       ex_alu_op,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             wb_mem_to_reg,
    output logic             wb_reg_write,
    output logic [REG_W-1:0] wb_dst,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             stall;
    logic             idex_bubble;
    ctrl_bundle       id_ctrl;

    idex_ctrl_t       idex_ctrl, idex_ctrl_next;
    logic [REG_W-1:0] idex_rt, idex_rt_next;
    logic [REG_W-1:0] idex_rd, idex_rd_next;
    logic [REG_W-1:0] ex_dst;

    logic             exmem_mem_read, exmem_mem_write;
    logic             exmem_mem_to_reg, exmem_reg_write;
    logic [REG_W-1:0] exmem_dst;

    logic             memwb_mem_to_reg, memwb_reg_write;
    logic [REG_W-1:0] memwb_dst;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .idex_mem_read    (idex_ctrl.mem_read),
        .idex_rt          (idex_rt),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .mem_branch_taken (mem_branch_taken),
        .stall            (stall)
    );

    // rs has no consumer past ID in this block, so only rt and rd are kept.
    always_comb begin
        id_ctrl = '{reg_dst:    id_reg_dst,
                    alu_src:    id_alu_src,
                    mem_to_reg: id_mem_to_reg,
                    reg_write:  id_reg_write,
                    mem_read:   id_mem_read,
                    mem_write:  id_mem_write,
                    branch:     id_branch,
                    jump:       id_jump,
                    alu_op:     id_alu_op};
        idex_bubble    = mem_branch_taken | stall | id_nop;
        idex_ctrl_next = IDEX_BUBBLE;
        idex_rt_next   = '0;
        idex_rd_next   = '0;
        if (!idex_bubble) begin
            idex_ctrl_next = to_idex(id_ctrl);
            idex_rt_next   = id_rt;
            idex_rd_next   = id_rd;
        end
    end

    assign ex_dst = idex_ctrl.reg_dst ? idex_rd : idex_rt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_ctrl <= IDEX_BUBBLE;
            idex_rt   <= '0;
            idex_rd   <= '0;
        end else begin
            idex_ctrl <= idex_ctrl_next;
            idex_rt   <= idex_rt_next;
            idex_rd   <= idex_rd_next;
        end
    end

    // A taken branch resolves in MEM, so the instruction now in EX is squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_reg_write  <= 1'b0;
            exmem_dst        <= '0;
        end else if (mem_branch_taken) begin
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_reg_write  <= 1'b0;
            exmem_dst        <= '0;
        end else begin
            exmem_mem_read   <= idex_ctrl.mem_read;
            exmem_mem_write  <= idex_ctrl.mem_write;
            exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
            exmem_reg_write  <= idex_ctrl.reg_write;
            exmem_dst        <= ex_dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memwb_mem_to_reg <= 1'b0;
            memwb_reg_write  <= 1'b0;
            memwb_dst        <= '0;
        end else begin
            memwb_mem_to_reg <= exmem_mem_to_reg;
            memwb_reg_write  <= exmem_reg_write;
            memwb_dst        <= exmem_dst;
        end
    end

    // Fetch side; the flush request is held low while reset is applied.
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign ifid_flush = ~rst & (mem_branch_taken | (id_jump & ~stall & ~id_nop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_reg_dst    = idex_ctrl.reg_dst;
    assign ex_alu_src    = idex_ctrl.alu_src;
    assign ex_branch     = idex_ctrl.branch;
    assign ex_alu_op     = idex_ctrl.alu_op;
    assign mem_mem_read  = exmem_mem_read;
    assign mem_mem_write = exmem_mem_write;
    assign wb_mem_to_reg = memwb_mem_to_reg;
    assign wb_reg_write  = memwb_reg_write;
    assign wb_dst        = memwb_dst;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Bench for pipe_ctrl_regs: directed load-use/flush/jump/saturation/reset
// scenarios with literal expectations, then randomized traffic against a model.
module tb_pipe_ctrl_regs;
    import cpu_pkg::*;

    localparam int CW  = 2;
    localparam int RW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_nop;
    logic          id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
    logic          id_mem_read, id_mem_write, id_branch, id_jump;
    logic [1:0]    id_alu_op;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          mem_branch_taken;
    logic          ex_reg_dst, ex_alu_src, ex_branch;
    logic [1:0]    ex_alu_op;
    logic          mem_mem_read, mem_mem_write;
    logic          wb_mem_to_reg, wb_reg_write;
    logic [RW-1:0] wb_dst;
    logic          pc_write, ifid_write, ifid_flush;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pipe_ctrl_regs #(.CNT_W(CW), .REG_W(RW)) dut (
        .clk(clk), .rst(rst), .id_nop(id_nop),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_branch_taken(mem_branch_taken),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each in-flight instruction is a record; the pipe is three slots (EX, MEM, WB).
    typedef struct packed {
        logic          reg_dst, alu_src, branch;
        logic [1:0]    alu_op;
        logic          mem_read, mem_write, mem_to_reg, reg_write;
        logic [RW-1:0] rt, dst;
    } minst_t;

    minst_t m_ex, m_mem, m_wb;
    int     m_sc, m_fc;

    function automatic minst_t from_id();
        minst_t r;
        r.reg_dst    = id_reg_dst;
        r.alu_src    = id_alu_src;
        r.branch     = id_branch && !id_jump;
        r.alu_op     = id_alu_op;
        r.mem_read   = id_mem_read;
        r.mem_write  = id_mem_write;
        r.mem_to_reg = id_mem_to_reg;
        r.reg_write  = id_reg_write;
        r.rt         = id_rt;
        r.dst        = id_reg_dst ? id_rd : id_rt;
        return r;
    endfunction

    function automatic logic exp_stall();
        if (mem_branch_taken) return 1'b0;
        if (!m_ex.mem_read || m_ex.rt == 0) return 1'b0;
        return (m_ex.rt == id_rs) || (m_ex.rt == id_rt);
    endfunction

    function automatic logic exp_flush();
        return mem_branch_taken || (id_jump && !exp_stall() && !id_nop);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0;
            m_sc <= 0;  m_fc <= 0;
        end else begin
            m_wb  <= m_mem;
            m_mem <= mem_branch_taken ? minst_t'(0) : m_ex;
            m_ex  <= (mem_branch_taken || exp_stall() || id_nop) ? minst_t'(0) : from_id();
            if (exp_stall() && m_sc < SAT) m_sc <= m_sc + 1;
            if (exp_flush() && m_fc < SAT) m_fc <= m_fc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("ex_reg_dst",    32'(ex_reg_dst),    32'(m_ex.reg_dst));
            chk("ex_alu_src",    32'(ex_alu_src),    32'(m_ex.alu_src));
            chk("ex_branch",     32'(ex_branch),     32'(m_ex.branch));
            chk("ex_alu_op",     32'(ex_alu_op),     32'(m_ex.alu_op));
            chk("mem_mem_read",  32'(mem_mem_read),  32'(m_mem.mem_read));
            chk("mem_mem_write", 32'(mem_mem_write), 32'(m_mem.mem_write));
            chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m_wb.mem_to_reg));
            chk("wb_reg_write",  32'(wb_reg_write),  32'(m_wb.reg_write));
            chk("wb_dst",        32'(wb_dst),        32'(m_wb.dst));
            chk("pc_write",      32'(pc_write),      32'(!exp_stall()));
            chk("ifid_write",    32'(ifid_write),    32'(!exp_stall()));
            chk("ifid_flush",    32'(ifid_flush),    32'(exp_flush()));
            chk("stall_cnt",     32'(stall_cnt),     32'(m_sc));
            chk("flush_cnt",     32'(flush_cnt),     32'(m_fc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_id(ctrl_bundle c, logic [RW-1:0] rs, logic [RW-1:0] rt,
                          logic [RW-1:0] rd, logic nop, logic mbt);
        id_reg_dst = c.reg_dst;     id_alu_src = c.alu_src;
        id_mem_to_reg = c.mem_to_reg; id_reg_write = c.reg_write;
        id_mem_read = c.mem_read;   id_mem_write = c.mem_write;
        id_branch = c.branch;       id_jump = c.jump;
        id_alu_op = c.alu_op;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_nop = nop; mem_branch_taken = mbt;
    endtask

    function automatic ctrl_bundle rtype();
        ctrl_bundle c = CTRL_BUBBLE;
        c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_R;
        return c;
    endfunction

    function automatic ctrl_bundle lw_c();
        ctrl_bundle c = CTRL_BUBBLE;
        c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
        c.mem_read = 1'b1; c.alu_op = ALUOP_MEM;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic chk_reset_values(string tag);
        chk({tag, "_ex_reg_dst"},    32'(ex_reg_dst),    32'd0);
        chk({tag, "_ex_alu_src"},    32'(ex_alu_src),    32'd0);
        chk({tag, "_ex_branch"},     32'(ex_branch),     32'd0);
        chk({tag, "_ex_alu_op"},     32'(ex_alu_op),     32'd0);
        chk({tag, "_mem_mem_read"},  32'(mem_mem_read),  32'd0);
        chk({tag, "_mem_mem_write"}, 32'(mem_mem_write), 32'd0);
        chk({tag, "_wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'd0);
        chk({tag, "_wb_reg_write"},  32'(wb_reg_write),  32'd0);
        chk({tag, "_wb_dst"},        32'(wb_dst),        32'd0);
        chk({tag, "_pc_write"},      32'(pc_write),      32'd1);
        chk({tag, "_ifid_write"},    32'(ifid_write),    32'd1);
        chk({tag, "_ifid_flush"},    32'(ifid_flush),    32'd0);
        chk({tag, "_stall_cnt"},     32'(stall_cnt),     32'd0);
        chk({tag, "_flush_cnt"},     32'(flush_cnt),     32'd0);
    endtask

    initial begin
        ctrl_bundle c;
        rst = 1'b1;
        c = CTRL_BUBBLE; c.jump = 1'b1;
        set_id(c, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        #3;
        chk_reset_values("reset");
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // R-type through all stages
        set_id(rtype(), 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        tick();
        chk("rtype_ex_alu_op", 32'(ex_alu_op), 32'd2);
        set_id(CTRL_BUBBLE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        tick();
        chk("rtype_wb_reg_write", 32'(wb_reg_write), 32'd1);
        chk("rtype_wb_dst", 32'(wb_dst), 32'd5);

        // lw $8 then add using $8
        set_id(lw_c(), 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(rtype(), 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
        #1;
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_ifid_write", 32'(ifid_write), 32'd0);
        tick();
        chk("lu_bubble_alu_op", 32'(ex_alu_op), 32'd0);
        chk("lu_bubble_reg_dst", 32'(ex_reg_dst), 32'd0);
        chk("lu_load_in_mem", 32'(mem_mem_read), 32'd1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        #1;
        chk("lu_released", 32'(pc_write), 32'd1);
        tick();
        chk("lu_add_issued_dst", 32'(ex_reg_dst), 32'd1);
        chk("lu_add_issued_op", 32'(ex_alu_op), 32'd2);

        // lw $0 then consumer of $0
        set_id(lw_c(), 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(rtype(), 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        #1;
        chk("r0_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("r0_issued", 32'(ex_reg_dst), 32'd1);
        chk("r0_stall_cnt", 32'(stall_cnt), 32'd1);

        // taken branch while a load-use pair is in ID/EX
        set_id(lw_c(), 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(rtype(), 5'd8, 5'd9, 5'd10, 1'b0, 1'b1);
        #1;
        chk("fl_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("fl_pc_write", 32'(pc_write), 32'd1);
        chk("fl_ifid_write", 32'(ifid_write), 32'd1);
        tick();
        chk("fl_ex_bubble", 32'(ex_alu_op), 32'd0);
        chk("fl_exmem_bubble", 32'(mem_mem_read), 32'd0);
        chk("fl_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("fl_flush_cnt", 32'(flush_cnt), 32'd1);

        // jump that also decodes as branch
        c = CTRL_BUBBLE; c.jump = 1'b1; c.branch = 1'b1; c.alu_op = ALUOP_BR;
        set_id(c, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("jmp_ifid_flush", 32'(ifid_flush), 32'd1);
        tick();
        chk("jmp_branch_cleared", 32'(ex_branch), 32'd0);
        chk("jmp_alu_op", 32'(ex_alu_op), 32'd1);
        chk("jmp_flush_cnt", 32'(flush_cnt), 32'd2);

        // NOP carrying undefined controls
        c = 'x;
        set_id(c, 'x, 'x, 'x, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nopx_ex_reg_dst", 32'(ex_reg_dst), 32'd0);
            chk("nopx_ex_alu_src", 32'(ex_alu_src), 32'd0);
            chk("nopx_ex_branch",  32'(ex_branch),  32'd0);
            chk("nopx_ex_alu_op",  32'(ex_alu_op),  32'd0);
            if (i >= 1) begin
                chk("nopx_mem_read",  32'(mem_mem_read),  32'd0);
                chk("nopx_mem_write", 32'(mem_mem_write), 32'd0);
            end
            if (i >= 2) begin
                chk("nopx_wb_m2r", 32'(wb_mem_to_reg), 32'd0);
                chk("nopx_wb_rw",  32'(wb_reg_write),  32'd0);
                chk("nopx_wb_dst", 32'(wb_dst),        32'd0);
            end
        end
        set_id(CTRL_BUBBLE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        // five more stalls: counter must stop at its maximum
        for (int i = 0; i < 5; i++) begin
            set_id(lw_c(), 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
            tick();
            set_id(rtype(), 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
            #1;
            chk("sat_pc_write", 32'(pc_write), 32'd0);
            tick();
            tick();
        end
        chk("sat_stall_cnt", 32'(stall_cnt), 32'(SAT));
        set_id(CTRL_BUBBLE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        tick(); tick(); tick();
        chk("sat_flush_cnt", 32'(flush_cnt), 32'(SAT));

        // reset in the middle of a stall
        set_id(lw_c(), 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(rtype(), 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
        #1;
        chk("rs_pre_pc_write", 32'(pc_write), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        tick();
        rst = 1'b0;
        tick();
        chk("rs_first_load_dst", 32'(ex_reg_dst), 32'd1);
        chk("rs_first_load_op", 32'(ex_alu_op), 32'd2);
        chk("rs_stall_cnt", 32'(stall_cnt), 32'd0);

        // randomized traffic with periodic reset to reopen the counters
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 249) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            c = ctrl_bundle'($urandom);
            c.mem_read = ($urandom_range(0, 2) != 0);
            set_id(c, RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                   RW'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 9) == 0));
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
